// File: rtl/config_sequencer.sv
// config_sequencer: walks word addresses through configuration stages, driving one-hot write enables
module config_sequencer #(
   parameter int STAGES  = 16,
   parameter int LUTSIZE = 6,
   localparam int STAGE_W = $clog2(STAGES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic [STAGE_W-1:0] stage_sel,
   input  logic               abort,
   input  logic               wren_in,
   output logic [STAGES-1:0]  wren_out,
   output logic [LUTSIZE-1:0] addr_out,
   output logic [STAGE_W-1:0] stage_out,
   output logic               busy,
   output logic               done,
   output logic [15:0]        progress,
   output logic               err
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [STAGE_W:0]   STAGES_V   = (STAGE_W+1)'(STAGES);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);
   localparam logic [STAGES-1:0]  ONE_HOT0   = STAGES'(1);

   state_t             state, state_n;
   logic [LUTSIZE-1:0] addr_n;
   logic [STAGE_W-1:0] stage_n, end_stage, end_n;
   logic [15:0]        prog_n;
   logic               err_n, start_ok, accept;

   assign busy = state == WRITE;
   assign done = state == DONE;

   // Decode the cycle's action (abort > start > word) and compute every next-state value
   always_comb begin
      state_n  = state;
      addr_n   = addr_out;
      stage_n  = stage_out;
      prog_n   = progress;
      err_n    = err;
      end_n    = end_stage;
      start_ok = !abort && start && state != WRITE && (!mode || {1'b0, stage_sel} < STAGES_V);
      accept   = reset && !abort && !start_ok && wren_in && state == WRITE;
      wren_out = accept ? ONE_HOT0 << stage_out : '0;
      if (abort) begin
         state_n = IDLE;
         addr_n  = busy ? '0 : addr_out;
         stage_n = busy ? '0 : stage_out;
      end else if (start_ok) begin
         state_n = WRITE;
         addr_n  = '0;
         prog_n  = '0;
         err_n   = 1'b0;
         stage_n = mode ? stage_sel : '0;
         end_n   = mode ? stage_sel : LAST_STAGE;
      end else begin
         err_n = err | start | (wren_in && state != WRITE);
         if (accept) begin
            addr_n  = addr_out + 1'b1;
            prog_n  = &progress ? progress : progress + 16'd1;
            state_n = (&addr_out && stage_out == end_stage) ? DONE : WRITE;
            stage_n = (&addr_out && stage_out != end_stage) ? stage_out + 1'b1 : stage_out;
         end
      end
   end

   // State and datapath registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr_out  <= '0;
         stage_out <= '0;
         progress  <= '0;
         err       <= 1'b0;
         end_stage <= '0;
      end else begin
         state     <= state_n;
         addr_out  <= addr_n;
         stage_out <= stage_n;
         progress  <= prog_n;
         err       <= err_n;
         end_stage <= end_n;
      end
   end
endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: scoreboard bench for config_sequencer (4x4, 3-stage and saturation builds)
module tb_config_sequencer;
   typedef struct {logic [3:0] wr; logic [1:0] a; logic [1:0] s;} exp_t;

   logic clk = 0, reset = 0;
   logic start = 0, mode = 0, abort = 0, wren = 0;
   logic [1:0] sel = 0;
   logic [3:0] wren_out;
   logic [1:0] addr_out, stage_out;
   logic busy, done, err;
   logic [15:0] progress;

   logic start3 = 0, mode3 = 0;
   logic [1:0] sel3 = 0;
   logic [2:0] wren_out3;
   logic [1:0] addr3, stage3;
   logic busy3, done3, err3;
   logic [15:0] prog3;

   logic start_s = 0, ws = 0;
   logic [1:0] wren_out_s;
   logic [14:0] addr_s;
   logic [0:0] stage_s, sel_s;
   logic busy_s, done_s, err_s;
   logic [15:0] prog_s;

   int checks = 0, errors = 0;
   exp_t q[$];

   config_sequencer #(.STAGES(4), .LUTSIZE(2)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .stage_sel(sel), .abort(abort),
      .wren_in(wren), .wren_out(wren_out), .addr_out(addr_out), .stage_out(stage_out),
      .busy(busy), .done(done), .progress(progress), .err(err));

   config_sequencer #(.STAGES(3), .LUTSIZE(2)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .mode(mode3), .stage_sel(sel3), .abort(1'b0),
      .wren_in(1'b0), .wren_out(wren_out3), .addr_out(addr3), .stage_out(stage3),
      .busy(busy3), .done(done3), .progress(prog3), .err(err3));

   config_sequencer #(.STAGES(2), .LUTSIZE(15)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .mode(1'b0), .stage_sel(sel_s), .abort(1'b0),
      .wren_in(ws), .wren_out(wren_out_s), .addr_out(addr_s), .stage_out(stage_s),
      .busy(busy_s), .done(done_s), .progress(prog_s), .err(err_s));

   always #5 clk = ~clk;

   task automatic push_seq(input int s0, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.s  = 2'(s0 + i / 4);
         e.a  = 2'(i % 4);
         e.wr = 4'b0001 << e.s;
         q.push_back(e);
      end
   endtask

   task automatic feed(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         wren = 1;
         #1;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: DUT wren_out=%b with no expected word", wren_out);
         end else begin
            e = q.pop_front();
            if ({wren_out, addr_out, stage_out} !== {e.wr, e.a, e.s}) begin
               errors++;
               $display("FAIL word: got wren=%b addr=%0d stage=%0d want wren=%b addr=%0d stage=%0d",
                        wren_out, addr_out, stage_out, e.wr, e.a, e.s);
            end
         end
         @(negedge clk);
      end
      wren = 0;
   endtask

   task automatic pulse_start(input logic m, input logic [1:0] s);
      @(negedge clk);
      start = 1; mode = m; sel = s;
      @(negedge clk);
      start = 0;
   endtask

   task automatic test_reset;
      wren = 1;
      #3;
      checks++;
      if ({wren_out, busy, done, err, addr_out, stage_out, progress} !== 27'd0) begin
         errors++;
         $display("FAIL reset_state: got wren=%b busy=%b done=%b err=%b addr=%0d stage=%0d prog=%0d want all 0",
                  wren_out, busy, done, err, addr_out, stage_out, progress);
      end
      @(negedge clk);
      reset = 1; wren = 0;
      @(negedge clk);
      wren = 1;
      #1;
      checks++;
      if (wren_out !== 4'b0) begin errors++; $display("FAIL idle_wren: got %b want 0000", wren_out); end
      @(negedge clk);
      wren = 0;
      checks++;
      if ({err, busy} !== 2'b10) begin errors++; $display("FAIL idle_wren_err: got err=%b busy=%b want 1 0", err, busy); end
   endtask

   task automatic test_full_pass;
      pulse_start(0, 0);
      checks++;
      if ({busy, done, err, addr_out, stage_out, progress} !== {3'b100, 20'd0}) begin
         errors++;
         $display("FAIL full_start: got busy=%b done=%b err=%b addr=%0d stage=%0d prog=%0d want 1 0 0 0 0 0",
                  busy, done, err, addr_out, stage_out, progress);
      end
      push_seq(0, 16);
      feed(16);
      checks++;
      if ({busy, done, err, addr_out, stage_out, progress} !== {3'b010, 2'd0, 2'd3, 16'd16}) begin
         errors++;
         $display("FAIL full_done: got busy=%b done=%b err=%b addr=%0d stage=%0d prog=%0d want 0 1 0 0 3 16",
                  busy, done, err, addr_out, stage_out, progress);
      end
      wren = 1;
      #1;
      checks++;
      if (wren_out !== 4'b0) begin errors++; $display("FAIL extra_word: got %b want 0000", wren_out); end
      @(negedge clk);
      wren = 0;
      checks++;
      if ({err, done, progress} !== {2'b11, 16'd16}) begin
         errors++;
         $display("FAIL extra_word_err: got err=%b done=%b prog=%0d want 1 1 16", err, done, progress);
      end
   endtask

   task automatic test_single;
      pulse_start(1, 2);
      checks++;
      if ({busy, err, addr_out, stage_out, progress} !== {2'b10, 2'd0, 2'd2, 16'd0}) begin
         errors++;
         $display("FAIL single_start: got busy=%b err=%b addr=%0d stage=%0d prog=%0d want 1 0 0 2 0",
                  busy, err, addr_out, stage_out, progress);
      end
      push_seq(2, 4);
      feed(4);
      checks++;
      if ({busy, done, addr_out, stage_out, progress} !== {2'b01, 2'd0, 2'd2, 16'd4}) begin
         errors++;
         $display("FAIL single_done: got busy=%b done=%b addr=%0d stage=%0d prog=%0d want 0 1 0 2 4",
                  busy, done, addr_out, stage_out, progress);
      end
   endtask

   task automatic test_bad_stage;
      @(negedge clk);
      start3 = 1; mode3 = 1; sel3 = 3;
      @(negedge clk);
      start3 = 0;
      checks++;
      if ({err3, busy3, done3} !== 3'b100) begin
         errors++;
         $display("FAIL bad_stage: got err=%b busy=%b done=%b want 1 0 0", err3, busy3, done3);
      end
      start3 = 1; sel3 = 2;
      @(negedge clk);
      start3 = 0;
      checks++;
      if ({err3, busy3, stage3} !== {2'b01, 2'd2}) begin
         errors++;
         $display("FAIL good_stage3: got err=%b busy=%b stage=%0d want 0 1 2", err3, busy3, stage3);
      end
   endtask

   task automatic test_abort;
      pulse_start(0, 0);
      push_seq(0, 6);
      feed(6);
      wren = 1; abort = 1;
      #1;
      checks++;
      if (wren_out !== 4'b0) begin errors++; $display("FAIL abort_wren: got %b want 0000", wren_out); end
      @(negedge clk);
      wren = 0; abort = 0;
      checks++;
      if ({busy, done, err, addr_out, stage_out, progress} !== {3'b000, 4'd0, 16'd6}) begin
         errors++;
         $display("FAIL abort_state: got busy=%b done=%b err=%b addr=%0d stage=%0d prog=%0d want 0 0 0 0 0 6",
                  busy, done, err, addr_out, stage_out, progress);
      end
   endtask

   task automatic test_back_to_back;
      pulse_start(0, 0);
      push_seq(0, 16);
      feed(5);
      start = 1; mode = 0;
      @(negedge clk);
      start = 0;
      checks++;
      if ({err, busy, addr_out, stage_out, progress} !== {2'b11, 2'd1, 2'd1, 16'd5}) begin
         errors++;
         $display("FAIL start_in_write: got err=%b busy=%b addr=%0d stage=%0d prog=%0d want 1 1 1 1 5",
                  err, busy, addr_out, stage_out, progress);
      end
      feed(11);
      checks++;
      if ({done, err, progress} !== {2'b11, 16'd16}) begin
         errors++;
         $display("FAIL rejected_pass_done: got done=%b err=%b prog=%0d want 1 1 16", done, err, progress);
      end
      start = 1; mode = 0; wren = 1;
      #1;
      checks++;
      if (wren_out !== 4'b0) begin errors++; $display("FAIL restart_drop: got %b want 0000", wren_out); end
      @(negedge clk);
      start = 0; wren = 0;
      checks++;
      if ({busy, done, err, addr_out, stage_out, progress} !== {3'b100, 20'd0}) begin
         errors++;
         $display("FAIL restart_state: got busy=%b done=%b err=%b addr=%0d stage=%0d prog=%0d want 1 0 0 0 0 0",
                  busy, done, err, addr_out, stage_out, progress);
      end
      abort = 1;
      @(negedge clk);
      abort = 0;
   endtask

   task automatic test_async_reset;
      pulse_start(0, 0);
      push_seq(0, 9);
      feed(9);
      wren = 1;
      #2;
      reset = 0;
      #1;
      checks++;
      if ({wren_out, busy, done, err, addr_out, stage_out, progress} !== 27'd0) begin
         errors++;
         $display("FAIL async_reset: got wren=%b busy=%b done=%b err=%b addr=%0d stage=%0d prog=%0d want all 0",
                  wren_out, busy, done, err, addr_out, stage_out, progress);
      end
      wren = 0;
      @(negedge clk);
      reset = 1;
      pulse_start(0, 0);
      push_seq(0, 16);
      feed(16);
      checks++;
      if ({done, busy, progress} !== {2'b10, 16'd16}) begin
         errors++;
         $display("FAIL post_reset_pass: got done=%b busy=%b prog=%0d want 1 0 16", done, busy, progress);
      end
   endtask

   task automatic test_saturation;
      @(negedge clk);
      start_s = 1;
      @(negedge clk);
      start_s = 0; ws = 1;
      repeat (65535) @(negedge clk);
      checks++;
      if ({busy_s, stage_s, addr_s, prog_s} !== {2'b11, 15'h7FFF, 16'hFFFF}) begin
         errors++;
         $display("FAIL sat_last_word: got busy=%b stage=%0d addr=%0h prog=%0h want 1 1 7fff ffff",
                  busy_s, stage_s, addr_s, prog_s);
      end
      @(negedge clk);
      ws = 0;
      checks++;
      if ({done_s, busy_s, stage_s, addr_s, prog_s} !== {3'b101, 15'h0, 16'hFFFF}) begin
         errors++;
         $display("FAIL sat_done: got done=%b busy=%b stage=%0d addr=%0h prog=%0h want 1 0 1 0 ffff",
                  done_s, busy_s, stage_s, addr_s, prog_s);
      end
   endtask

   initial begin
      sel_s = 0;
      test_reset;
      test_full_pass;
      test_single;
      test_bad_stage;
      test_abort;
      test_back_to_back;
      test_async_reset;
      test_saturation;
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
